lb_cl: RTL and testbench

Line-buffer bank plus sliding-window convolution engine for the Conv2D datapath. It holds FILTER_SIZE image rows in circular line buffers and, on a start pulse, sweeps an F×F kernel across them, emitting one 16-bit result per window position. Conv2D's write/replace state machine sits above it and owns row sequencing.

---
 rtl/lb_cl_pkg.sv | 41 ++++
 rtl/lb_cl_if.sv | 40 ++++
 rtl/lb_cl_lb.sv | 93 +++++++++
 rtl/lb_cl.sv | 146 ++++++++++++++
 tb/tb_lb_cl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_cl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lb_cl_pkg
// Purpose  : Shared constants, engine state type and the output saturation
//            helper for the line-buffer / convolution engine.
// Revision : 1.0 - initial release
// ============================================================================
package lb_cl_pkg;

  localparam int FILTER_SIZE = 5;                 // kernel edge and number of line buffers
  localparam int SIZE_LB     = 28;                // pixels per line buffer (<= 127)
  localparam int ADDR_W      = 7;                 // line-buffer address width
  localparam int PIX_W       = 8;                 // stored pixel / weight width
  localparam int ACC_W       = 24;                // signed accumulator width
  localparam int OUT_W       = 16;                // signed result width
  localparam int ROW_W       = $clog2(FILTER_SIZE);
  localparam int NUM_WIN     = SIZE_LB - FILTER_SIZE + 1;
  localparam int KERNEL_W    = FILTER_SIZE * FILTER_SIZE * PIX_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 24'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -24'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } eng_state_e;

  // Clamp the accumulator into the signed 16-bit result range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
    if (acc > SAT_MAX) begin
      return 16'sh7fff;
    end else if (acc < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return acc[OUT_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/lb_cl_if.sv
`default_nettype none
// ============================================================================
// Module   : lb_cl_if
// Purpose  : Bus bundle between the Conv2D controller (master) and the
//            line-buffer / convolution engine (slave).
//   wr_en      : one-hot row write enable
//   wr_data    : pixel in (low byte stored)
//   fl         : F x F signed 8-bit kernel
//   start, k   : sweep launch level and row rotation
//   full, line_valid, wr_addr : per-buffer status
//   out_data, out_valid, ready : result stream and end-of-sweep strobe
// Revision : 1.0 - initial release
// ============================================================================
interface lb_cl_if;
  import lb_cl_pkg::*;

  logic [FILTER_SIZE-1:0]        wr_en;
  logic [15:0]                   wr_data;
  logic [KERNEL_W-1:0]           fl;
  logic                          start;
  logic [3:0]                    k;
  logic [FILTER_SIZE-1:0]        full;
  logic [FILTER_SIZE-1:0]        line_valid;
  logic [FILTER_SIZE*ADDR_W-1:0] wr_addr;
  logic [OUT_W-1:0]              out_data;
  logic                          out_valid;
  logic                          ready;

  modport master (
    output wr_en, wr_data, fl, start, k,
    input  full, line_valid, wr_addr, out_data, out_valid, ready
  );

  modport slave (
    input  wr_en, wr_data, fl, start, k,
    output full, line_valid, wr_addr, out_data, out_valid, ready
  );

endinterface
`default_nettype wire

// File: rtl/lb_cl_lb.sv
`default_nettype none
// ============================================================================
// Module   : lb_cl_lb
// Purpose  : Single circular line buffer with a registered multi-byte read.
//   clk, rst   : clock, asynchronous active-low reset
//   wr_en      : store wr_data at wr_addr and advance the write pointer
//   wr_data    : pixel byte
//   rd_addr    : base address; rd_data returns bytes rd_addr..rd_addr+RD_BYTES-1
//   rd_data    : byte j at [8j +: 8]; addresses past the end read as 0
//   full       : buffer holds DEPTH pixels
//   wr_addr    : next write address
// Revision : 1.0 - initial release
// ============================================================================
module lb_cl_lb
  import lb_cl_pkg::*;
#(
  parameter int DEPTH    = SIZE_LB,
  parameter int RD_BYTES = FILTER_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [PIX_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [RD_BYTES*PIX_W-1:0] rd_data,
  output logic                      full,
  output logic [ADDR_W-1:0]         wr_addr
);

  localparam int MEM_AW = $clog2(DEPTH);

  logic [PIX_W-1:0]          mem [DEPTH];
  logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic                      full_q, full_d;
  logic [MEM_AW-1:0]         wr_ptr;
  logic [RD_BYTES*PIX_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W:0]           rd_idx;

  // Write pointer: a write while full restarts the row at address 0.
  always_comb begin
    wr_addr_d = wr_addr_q;
    full_d    = full_q;
    wr_ptr    = wr_addr_q[MEM_AW-1:0];
    if (wr_en) begin
      if (full_q) begin
        wr_ptr    = '0;
        wr_addr_d = ADDR_W'(1);
        full_d    = 1'b0;
      end else if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
        wr_addr_d = '0;
        full_d    = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end
  end

  // Window read; the extra index bit keeps rd_addr+j from wrapping.
  always_comb begin
    rd_data_d = '0;
    rd_idx    = '0;
    for (int j = 0; j < RD_BYTES; j++) begin
      rd_idx = {1'b0, rd_addr} + (ADDR_W + 1)'(j);
      if (rd_idx < (ADDR_W + 1)'(DEPTH)) begin
        rd_data_d[j*PIX_W +: PIX_W] = mem[rd_idx[MEM_AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_q <= '0;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      full_q    <= full_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign wr_addr = wr_addr_q;

endmodule
`default_nettype wire

// File: rtl/lb_cl.sv
`default_nettype none
// ============================================================================
// Module   : lb_cl
// Purpose  : F line buffers plus a sliding-window F x F convolution engine.
//            A start edge sweeps the kernel across all buffers, emitting one
//            saturated 16-bit result per window column, then pulses ready.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : lb_cl_if slave (write port, kernel, start/k, status, results)
// Revision : 1.0 - initial release
// ============================================================================
module lb_cl
  import lb_cl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  lb_cl_if.slave bus
);

  eng_state_e                   state_q, state_d;
  logic                         start_prev_q;
  logic                         start_edge;
  logic [ROW_W-1:0]             k_q, k_d;
  logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
  logic                         rd_vld_q, rd_vld_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]      out_data_q, out_data_d;
  logic                         ready_q, ready_d;
  logic [FILTER_SIZE*PIX_W-1:0] rd_data [FILTER_SIZE];
  logic [FILTER_SIZE-1:0]       full;
  logic signed [ACC_W-1:0]      acc, pix_s, wgt_s;
  logic [ROW_W:0]               row_sum;
  logic [ROW_W-1:0]             phys;
  logic                         unused_wr_hi;

  // Only the low byte of a pixel is stored.
  assign unused_wr_hi = ^bus.wr_data[15:PIX_W];

  generate
    for (genvar i = 0; i < FILTER_SIZE; i++) begin : g_lb
      lb_cl_lb #(
        .DEPTH    (SIZE_LB),
        .RD_BYTES (FILTER_SIZE)
      ) u_lb (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en[i]),
        .wr_data (bus.wr_data[PIX_W-1:0]),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data[i]),
        .full    (full[i]),
        .wr_addr (bus.wr_addr[i*ADDR_W +: ADDR_W])
      );
    end
  endgenerate

  assign start_edge = bus.start & ~start_prev_q;

  // MAC tree over the registered window. k_q is already reduced mod F, so a
  // single conditional subtract maps logical row r onto its physical buffer.
  always_comb begin
    acc     = '0;
    pix_s   = '0;
    wgt_s   = '0;
    row_sum = '0;
    phys    = '0;
    for (int r = 0; r < FILTER_SIZE; r++) begin
      row_sum = {1'b0, k_q} + (ROW_W + 1)'(r);
      if (row_sum >= (ROW_W + 1)'(FILTER_SIZE)) begin
        row_sum = row_sum - (ROW_W + 1)'(FILTER_SIZE);
      end
      phys = row_sum[ROW_W-1:0];
      for (int c = 0; c < FILTER_SIZE; c++) begin
        pix_s = ACC_W'(rd_data[phys][c*PIX_W +: PIX_W]);
        wgt_s = ACC_W'($signed(bus.fl[(r*FILTER_SIZE+c)*PIX_W +: PIX_W]));
        acc   = acc + pix_s * wgt_s;
      end
    end
  end

  // Engine FSM. rd_vld_q marks that the buffers' registered data this cycle
  // belongs to an issued window; results follow it by one more register.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rd_addr_d   = rd_addr_q;
    rd_vld_d    = 1'b0;
    out_valid_d = rd_vld_q;
    out_data_d  = rd_vld_q ? sat_out(acc) : out_data_q;
    ready_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_SWEEP;
          k_d       = ROW_W'(int'(bus.k) % FILTER_SIZE);
          rd_addr_d = '0;
        end
      end
      ST_SWEEP: begin
        rd_vld_d = 1'b1;
        if (rd_addr_q == ADDR_W'(SIZE_LB - FILTER_SIZE)) begin
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // Last result is on the output now; ready follows it next cycle.
        if (out_valid_q && !rd_vld_q) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      k_q          <= '0;
      rd_addr_q    <= '0;
      rd_vld_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.start;
      k_q          <= k_d;
      rd_addr_q    <= rd_addr_d;
      rd_vld_q     <= rd_vld_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.full       = full;
  assign bus.line_valid = full;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ready      = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_lb_cl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_cl
// Purpose  : Self-checking bench for lb_cl against a behavioural model of the
//            line buffers and the windowed convolution.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lb_cl;
  import lb_cl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lb_cl_if intf ();

  lb_cl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  int total;
  int bad;
  int m_mem [FILTER_SIZE][SIZE_LB];
  int m_wa  [FILTER_SIZE];
  bit m_full[FILTER_SIZE];
  int w     [FILTER_SIZE][FILTER_SIZE];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_win(input int kv, input int a);
    int acc = 0;
    for (int r = 0; r < FILTER_SIZE; r++)
      for (int c = 0; c < FILTER_SIZE; c++)
        acc += m_mem[(kv + r) % FILTER_SIZE][a + c] * w[r][c];
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic load_w();
    for (int r = 0; r < FILTER_SIZE; r++)
      for (int c = 0; c < FILTER_SIZE; c++)
        intf.fl[(r*FILTER_SIZE+c)*PIX_W +: PIX_W] = 8'(w[r][c]);
  endtask

  task automatic set_w_all(input int v);
    for (int r = 0; r < FILTER_SIZE; r++)
      for (int c = 0; c < FILTER_SIZE; c++)
        w[r][c] = v;
    load_w();
  endtask

  // One write; the high byte is random to show it is discarded.
  task automatic wr(input int b, input int v);
    @(negedge clk);
    intf.wr_en    = '0;
    intf.wr_en[b] = 1'b1;
    intf.wr_data  = {8'($urandom), 8'(v)};
    if (m_full[b]) begin
      m_mem[b][0] = v & 255;
      m_wa[b]     = 1;
      m_full[b]   = 1'b0;
    end else begin
      m_mem[b][m_wa[b]] = v & 255;
      if (m_wa[b] == SIZE_LB - 1) begin
        m_wa[b]   = 0;
        m_full[b] = 1'b1;
      end else begin
        m_wa[b]++;
      end
    end
  endtask

  task automatic wr_idle();
    @(negedge clk);
    intf.wr_en = '0;
  endtask

  task automatic check_bufs(input string tag);
    logic [FILTER_SIZE-1:0] ef;
    for (int b = 0; b < FILTER_SIZE; b++) ef[b] = m_full[b];
    check({tag, "_full"}, intf.full, ef);
    check({tag, "_lv"}, intf.line_valid, ef);
    for (int b = 0; b < FILTER_SIZE; b++)
      check({tag, "_wa"}, intf.wr_addr[b*ADDR_W +: ADDR_W], m_wa[b]);
  endtask

  // Launch a sweep and check every result, latency, continuity and ready.
  task automatic sweep(input int kv, input bit glitch, input string tag);
    int exp_v[NUM_WIN];
    int cnt = 0, first = -1, last = -1, gaps = 0, rdy_cnt = 0, rdy_at = -1;
    for (int a = 0; a < NUM_WIN; a++) exp_v[a] = exp_win(kv, a);
    @(negedge clk);
    intf.k     = 4'(kv);
    intf.start = 1'b1;
    for (int cyc = 1; cyc <= NUM_WIN + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        intf.start = 1'b0;
        intf.k     = 4'($urandom);
      end
      if (glitch && cyc == 6) intf.start = 1'b1;
      if (glitch && cyc == 8) intf.start = 1'b0;
      if (intf.out_valid) begin
        if (first < 0) first = cyc;
        else if (cyc != last + 1) gaps++;
        last = cyc;
        if (cnt < NUM_WIN)
          check({tag, "_data"}, longint'($signed(intf.out_data)), exp_v[cnt]);
        cnt++;
      end
      if (intf.ready) begin
        rdy_cnt++;
        rdy_at = cyc;
      end
    end
    check({tag, "_count"}, cnt, NUM_WIN);
    check({tag, "_first_lat"}, first, 3);
    check({tag, "_gaps"}, gaps, 0);
    check({tag, "_ready_cnt"}, rdy_cnt, 1);
    check({tag, "_ready_at"}, rdy_at, last + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    intf.wr_en   = '0;
    intf.wr_data = '0;
    intf.fl      = '0;
    intf.start   = 1'b0;
    intf.k       = '0;
    for (int b = 0; b < FILTER_SIZE; b++) begin
      m_wa[b]   = 0;
      m_full[b] = 1'b0;
      for (int a = 0; a < SIZE_LB; a++) m_mem[b][a] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_full", intf.full, 0);
    check("rst_lv", intf.line_valid, 0);
    check("rst_wa", intf.wr_addr, 0);
    check("rst_data", intf.out_data, 0);
    check("rst_valid", intf.out_valid, 0);
    check("rst_ready", intf.ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // Fill every buffer, then refill buffer 0.
    for (int b = 0; b < FILTER_SIZE; b++)
      for (int a = 0; a < SIZE_LB; a++) wr(b, 1);
    wr_idle();
    check("fill_full", intf.full, 5'b11111);
    check_bufs("fill");
    wr(0, 1);
    wr_idle();
    check("refill_full0", intf.full[0], 0);
    check("refill_wa0", intf.wr_addr[ADDR_W-1:0], 1);
    for (int a = 1; a < SIZE_LB; a++) wr(0, 1);
    wr_idle();
    check_bufs("refill_done");

    // Box filter, then again with a second start edge mid-sweep.
    set_w_all(1);
    sweep(0, 1'b0, "box");
    sweep(0, 1'b1, "box_glitch");

    // Rotation: buffer i holds value i.
    for (int b = 0; b < FILTER_SIZE; b++)
      for (int a = 0; a < SIZE_LB; a++) wr(b, b);
    wr_idle();
    set_w_all(0);
    w[0][0] = 1;
    load_w();
    sweep(2, 1'b0, "rot");

    // Saturation both ways.
    for (int b = 0; b < FILTER_SIZE; b++)
      for (int a = 0; a < SIZE_LB; a++) wr(b, 255);
    wr_idle();
    set_w_all(127);
    sweep(0, 1'b0, "sat_hi");
    set_w_all(-128);
    sweep(0, 1'b0, "sat_lo");

    // Column order with the centre tap only.
    for (int b = 0; b < FILTER_SIZE; b++)
      for (int a = 0; a < SIZE_LB; a++) wr(b, a);
    wr_idle();
    set_w_all(0);
    w[2][2] = 1;
    load_w();
    sweep(0, 1'b0, "col");

    // Randomised writes, kernels and rotations.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(10, 60);
      for (int i = 0; i < n; i++) wr($urandom_range(0, FILTER_SIZE - 1), $urandom_range(0, 255));
      wr_idle();
      check_bufs("rnd");
      for (int r = 0; r < FILTER_SIZE; r++)
        for (int c = 0; c < FILTER_SIZE; c++)
          w[r][c] = int'($urandom_range(0, 255)) - 128;
      load_w();
      sweep($urandom_range(0, 15), it[0], "rnd");
    end

    // Reset in the middle of a sweep.
    @(negedge clk);
    intf.k     = '0;
    intf.start = 1'b1;
    repeat (8) @(negedge clk);
    intf.start = 1'b0;
    rst = 1'b0;
    #1;
    for (int b = 0; b < FILTER_SIZE; b++) begin
      m_wa[b]   = 0;
      m_full[b] = 1'b0;
    end
    check("mid_rst_valid", intf.out_valid, 0);
    check("mid_rst_ready", intf.ready, 0);
    check("mid_rst_data", intf.out_data, 0);
    check_bufs("mid_rst");
    repeat (3) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (intf.out_valid || intf.ready) seen++;
    end
    check("post_rst_quiet", seen, 0);
    check_bufs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
